// File: rtl/tmcu_pkg.sv
// tmcu_pkg: shared types and default widths for the APB requester slice.
//   apb_state_e   APB requester phase (IDLE / SETUP / ACCESS)
//   APB_ADDR_W    default APB address width
//   APB_DATA_W    default APB data width
//   APB_TIMEOUT   default ACCESS-phase wait limit (0 = wait forever)
package tmcu_pkg;

  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  localparam int APB_ADDR_W  = 8;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;

endpackage

// File: rtl/tmcu_apb_master.sv
// tmcu_apb_master: APB requester bridging a valid/ready CPU request port onto
// the peripheral APB bus. One transfer in flight; a transfer that sees no
// pready within TIMEOUT ACCESS cycles is aborted and reported as an error.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           CPU request handshake (ready only in IDLE)
//   req_write/req_addr/req_wdata  request fields, sampled on the accept cycle
//   resp_valid                    one-cycle completion pulse
//   resp_rdata                    read data (0 for writes and aborts)
//   resp_err                      1 = transfer aborted by timeout
//   psel/penable/pwrite/paddr/pwdata   APB requester outputs (registered)
//   prdata/pready                 APB completer inputs
import tmcu_pkg::*;

module tmcu_apb_master #(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  // A zero TIMEOUT still gets a 1-bit counter so the vector is never empty.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  // Next-state logic. Response fields default to idle values so the
  // completion pulse lasts exactly one cycle; bus address/data/direction
  // default to holding so they do not toggle between transfers.
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    wait_cnt_d   = wait_cnt_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      APB_IDLE: begin
        if (req_valid) begin
          pwrite_d   = req_write;
          paddr_d    = req_addr;
          pwdata_d   = req_wdata;
          psel_d     = 1'b1;
          penable_d  = 1'b0;
          wait_cnt_d = '0;
          state_d    = APB_SETUP;
        end
      end

      APB_SETUP: begin
        penable_d = 1'b1;
        state_d   = APB_ACCESS;
      end

      APB_ACCESS: begin
        // pready is checked first so a ready arriving on the last allowed
        // cycle completes normally instead of aborting.
        if (pready) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = pwrite_q ? '0 : prdata;
          state_d      = APB_IDLE;
        end else if ((TIMEOUT != 0) && (wait_cnt_q == CNT_LAST)) begin
          psel_d       = 1'b0;
          penable_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          state_d      = APB_IDLE;
        end else if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = APB_IDLE;
      end
    endcase
  end

  // All state and outputs are registered; reset drops psel/penable at once,
  // so an interrupted transfer never produces a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= APB_IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign req_ready  = (state_q == APB_IDLE);
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_tmcu_apb_master.sv
// tb_tmcu_apb_master: directed bench for tmcu_apb_master with a small APB
// completer model (register file) whose pready behaviour is selectable:
//   NORMAL  registered pready, one wait state, no lingering
//   LINGER  registered pready that stays high one cycle into IDLE
//   STUCK   pready tied low (forces the timeout abort)
//   LATE    pready raised combinationally in the 16th ACCESS cycle
module tb_tmcu_apb_master;

  localparam int M_NORMAL = 0;
  localparam int M_LINGER = 1;
  localparam int M_STUCK  = 2;
  localparam int M_LATE   = 3;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  int total_checks;
  int fail_count;
  int slave_mode;

  tmcu_apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .pready     (pready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Completer model: word-addressed register file plus pready generation.
  logic [31:0] mem [0:63];
  logic        pready_r;
  logic [7:0]  acc_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pready_r <= 1'b0;
      acc_cnt  <= 8'd0;
    end else begin
      if (slave_mode == M_LINGER) pready_r <= psel & penable;
      else                        pready_r <= psel & penable & ~pready_r;
      acc_cnt <= (psel && penable) ? acc_cnt + 8'd1 : 8'd0;
      if (psel && penable && pready && pwrite) mem[paddr[7:2]] <= pwdata;
    end
  end

  always_comb begin
    pready = 1'b0;
    case (slave_mode)
      M_NORMAL, M_LINGER: pready = pready_r;
      M_STUCK:            pready = 1'b0;
      M_LATE:             pready = psel & penable & (acc_cnt == 8'd15);
      default:            pready = 1'b0;
    endcase
  end

  assign prdata = mem[paddr[7:2]];

  typedef struct {
    string       name;
    int          mode;
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_access;
  } vec_t;

  function automatic vec_t mkVec(input string name, input int mode, input logic write,
                                 input logic [7:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input int exp_lat, input int exp_access);
    vec_t v;
    v.name = name; v.mode = mode; v.write = write; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_access = exp_access;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete transfer: request on the cycle after a falling edge, then
  // observe every cycle (sampled on falling edges) until the response.
  task automatic applyStimulus(input vec_t v);
    bit          done;
    int          lat, n_setup, n_access, bad_hold;
    logic [31:0] rdata;
    logic        err, psel_at_resp;
    done = 0; lat = 0; n_setup = 0; n_access = 0; bad_hold = 0;
    rdata = '0; err = 1'b0; psel_at_resp = 1'b0;
    slave_mode = v.mode;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    checkOutput({v.name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    for (int n = 1; n <= 40 && !done; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (psel && !penable) n_setup++;
      if (psel && penable) begin
        n_access++;
        if (paddr !== v.addr || pwrite !== v.write || (v.write && pwdata !== v.wdata))
          bad_hold++;
      end
      if (resp_valid) begin
        done = 1; lat = n; rdata = resp_rdata; err = resp_err; psel_at_resp = psel;
      end
    end
    if (!done) begin
      total_checks++;
      fail_count++;
      $display("[TB] FAIL %s response: none within 40 cycles, expected at cycle %0d", v.name, v.exp_lat);
    end else begin
      checkOutput({v.name, " latency"},    lat,      v.exp_lat);
      checkOutput({v.name, " rdata"},      rdata,    v.exp_rdata);
      checkOutput({v.name, " err"},        {31'd0, err}, {31'd0, v.exp_err});
      checkOutput({v.name, " setup_cyc"},  n_setup,  32'd1);
      checkOutput({v.name, " access_cyc"}, n_access, v.exp_access);
      checkOutput({v.name, " bus_hold"},   bad_hold, 32'd0);
      checkOutput({v.name, " psel_idle"},  {31'd0, psel_at_resp}, 32'd0);
      @(negedge clk);
      checkOutput({v.name, " pulse_1cyc"}, {31'd0, resp_valid}, 32'd0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    int setup1, setup2, resp1, resp2, n_resp, errs;
    logic [31:0] rd1, rd2;

    total_checks = 0;
    fail_count   = 0;
    slave_mode   = M_NORMAL;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 8'h00;
    req_wdata    = 32'h0;

    vecs[0] = mkVec("wr00",   M_NORMAL, 1'b1, 8'h00, 32'hA5A5_0001, 32'h0,         1'b0, 4,  2);
    vecs[1] = mkVec("wr04",   M_NORMAL, 1'b1, 8'h04, 32'hFFFF_0000, 32'h0,         1'b0, 4,  2);
    vecs[2] = mkVec("rd04",   M_NORMAL, 1'b0, 8'h04, 32'h0,         32'hFFFF_0000, 1'b0, 4,  2);
    vecs[3] = mkVec("rd00",   M_NORMAL, 1'b0, 8'h00, 32'h0,         32'hA5A5_0001, 1'b0, 4,  2);
    vecs[4] = mkVec("wr3c",   M_NORMAL, 1'b1, 8'h3C, 32'h1234_5678, 32'h0,         1'b0, 4,  2);
    vecs[5] = mkVec("rd3c",   M_NORMAL, 1'b0, 8'h3C, 32'h0,         32'h1234_5678, 1'b0, 4,  2);
    vecs[6] = mkVec("tmo_rd", M_STUCK,  1'b0, 8'h04, 32'h0,         32'h0,         1'b1, 18, 16);
    vecs[7] = mkVec("late_rd",M_LATE,   1'b0, 8'h04, 32'h0,         32'hFFFF_0000, 1'b0, 18, 16);

    // Reset values.
    repeat (2) @(negedge clk);
    checkOutput("rst req_ready",  {31'd0, req_ready},  32'd1);
    checkOutput("rst psel",       {31'd0, psel},       32'd0);
    checkOutput("rst penable",    {31'd0, penable},    32'd0);
    checkOutput("rst pwrite",     {31'd0, pwrite},     32'd0);
    checkOutput("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    checkOutput("rst resp_err",   {31'd0, resp_err},   32'd0);
    checkOutput("rst paddr",      {24'd0, paddr},      32'd0);
    checkOutput("rst pwdata",     pwdata,              32'd0);
    checkOutput("rst resp_rdata", resp_rdata,          32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      if (i == 0) checkOutput("slave reg0", mem[0], 32'hA5A5_0001);
    end

    // Back-to-back reads with req_valid held high and a lingering pready.
    slave_mode = M_LINGER;
    setup1 = -1; setup2 = -1; resp1 = -1; resp2 = -1; n_resp = 0; errs = 0;
    rd1 = '0; rd2 = '0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h04;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (psel && !penable) begin
        if (setup1 < 0) setup1 = n;
        else if (setup2 < 0) setup2 = n;
      end
      if (resp_valid) begin
        n_resp++;
        if (resp_err) errs++;
        if (resp1 < 0) begin resp1 = n; rd1 = resp_rdata; end
        else if (resp2 < 0) begin resp2 = n; rd2 = resp_rdata; end
      end
      if (n == 5) req_valid = 1'b0;
    end
    checkOutput("b2b setup1", setup1, 32'd1);
    checkOutput("b2b resp1",  resp1,  32'd4);
    checkOutput("b2b setup2", setup2, 32'd5);
    checkOutput("b2b resp2",  resp2,  32'd8);
    checkOutput("b2b nresp",  n_resp, 32'd2);
    checkOutput("b2b errs",   errs,   32'd0);
    checkOutput("b2b rdata1", rd1,    32'hFFFF_0000);
    checkOutput("b2b rdata2", rd2,    32'hFFFF_0000);

    // Asynchronous reset in the middle of ACCESS.
    slave_mode = M_NORMAL;
    n_resp = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 8'h08;
    req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("arst in_access", {31'd0, psel & penable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst psel",    {31'd0, psel},    32'd0);
    checkOutput("arst penable", {31'd0, penable}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
    end
    rst_n = 1'b1;
    checkOutput("arst req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
    end
    checkOutput("arst no_resp", n_resp, 32'd0);
    applyStimulus(mkVec("post_rst_rd", M_NORMAL, 1'b0, 8'h04, 32'h0, 32'hFFFF_0000, 1'b0, 4, 2));

    $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
    $finish;
  end

endmodule
